// File: rtl/qrr_mux_if.sv
// Valid/ready stream carrying a flat data word; master drives valid/data, slave drives ready.
interface qrr_mux_if #(
  parameter int unsigned W = 17
) ();
  logic         valid;
  logic         ready;
  logic [W-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/qrr_mux.sv
// Transaction-atomic round-robin merge of NUM_IN queue streams onto one tagged output stream.
module qrr_mux #(
  parameter int unsigned NUM_IN = 2,
  parameter int unsigned W_DATA = 16,
  parameter int unsigned LVL    = 1
) (
  input  logic      clk,
  input  logic      rst,
  qrr_mux_if.slave  din [NUM_IN],
  qrr_mux_if.master dout
);

  localparam int unsigned W_CTRL = (NUM_IN > 2) ? $clog2(NUM_IN) : 1;
  localparam int unsigned W_IN   = LVL + W_DATA;
  localparam int unsigned W_OUT  = LVL + W_CTRL + W_DATA;

  typedef enum logic {UNLOCKED = 1'b0, LOCKED = 1'b1} state_e;

  state_e              state_q, state_d;
  logic [W_CTRL-1:0]   g_q, g_d;
  logic [W_CTRL-1:0]   p_q, p_d;
  logic                out_valid_q, out_valid_d;
  logic [W_OUT-1:0]    out_data_q, out_data_d;

  logic [NUM_IN-1:0]   in_valid;
  logic [NUM_IN-1:0]   in_ready;
  logic [W_IN-1:0]     in_data [NUM_IN];

  logic                found;
  logic [W_CTRL-1:0]   src;
  logic [W_CTRL-1:0]   idx;
  logic [W_IN-1:0]     src_beat;
  logic                src_eot;
  logic                can_load;
  logic                acc;

  // Flatten the interface array so the arbiter can index it with a variable
  for (genvar i = 0; i < NUM_IN; i++) begin : g_in
    assign in_valid[i]  = din[i].valid;
    assign in_data[i]   = din[i].data;
    assign din[i].ready = in_ready[i];
  end

  assign dout.valid = out_valid_q;
  assign dout.data  = out_data_q;

  // The output slot can take a beat when empty or when it is draining this cycle
  assign can_load = !out_valid_q || dout.ready;

  // Candidate: the locked input, or the first valid input scanning from the pointer
  always_comb begin
    found = 1'b0;
    src   = g_q;
    idx   = '0;
    if (state_q == LOCKED) begin
      found = in_valid[g_q];
    end else begin
      for (int unsigned k = 0; k < NUM_IN; k++) begin
        idx = W_CTRL'((32'(p_q) + k) % NUM_IN);
        if (!found && in_valid[idx]) begin
          found = 1'b1;
          src   = idx;
        end
      end
    end
  end

  assign src_beat = in_data[src];
  assign src_eot  = &src_beat[W_IN-1 -: LVL];
  assign acc      = rst && found && can_load;

  // State and output-slot register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= UNLOCKED;
      g_q         <= '0;
      p_q         <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      g_q         <= g_d;
      p_q         <= p_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  // Next state: lock on a non-final beat, release and advance the pointer on eot
  always_comb begin
    state_d     = state_q;
    g_d         = g_q;
    p_d         = p_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (acc) begin
      out_valid_d = 1'b1;
      out_data_d  = {src_beat[W_IN-1 -: LVL], src, src_beat[W_DATA-1:0]};
      if (src_eot) begin
        state_d = UNLOCKED;
        p_d     = (32'(src) + 32'd1 == NUM_IN) ? '0 : W_CTRL'(32'(src) + 32'd1);
      end else begin
        state_d = LOCKED;
        g_d     = src;
      end
    end else if (dout.ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Ready goes only to the selected input, and only when its beat will be taken
  always_comb begin
    in_ready = '0;
    if (acc) begin
      in_ready[src] = 1'b1;
    end
  end

endmodule

// File: tb/tb_qrr_mux.sv
// Self-checking bench for qrr_mux with three inputs: directed scenarios plus randomized traffic.
module tb_qrr_mux;

  localparam int unsigned N  = 3;
  localparam int unsigned WD = 16;
  localparam int unsigned WI = 17;
  localparam int unsigned WO = 19;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  in_valid;
  logic [N-1:0]  in_ready;
  logic [WI-1:0] in_data [N];
  logic          dout_ready;
  logic          dv;
  logic [WO-1:0] dd;

  int n_tests = 0;
  int n_fail  = 0;

  qrr_mux_if #(.W(WI)) din_if [N] ();
  qrr_mux_if #(.W(WO)) dout_if ();

  for (genvar g = 0; g < N; g++) begin : g_drv
    assign din_if[g].valid = in_valid[g];
    assign din_if[g].data  = in_data[g];
    assign in_ready[g]     = din_if[g].ready;
  end
  assign dout_if.ready = dout_ready;
  assign dv = dout_if.valid;
  assign dd = dout_if.data;

  qrr_mux #(.NUM_IN(N), .W_DATA(WD), .LVL(1)) dut (
    .clk  (clk),
    .rst  (rst),
    .din  (din_if),
    .dout (dout_if)
  );

  always #5 clk = ~clk;

  // Record every accepted input beat (as the output should show it) and every delivered output beat
  logic [WO-1:0] acc_q [$];
  logic [WO-1:0] out_q [$];
  logic [N-1:0]  acc_last = '0;
  int            n1234 = 0;

  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      acc_last[i] <= in_valid[i] && in_ready[i] && rst;
      if (in_valid[i] && in_ready[i] && rst)
        acc_q.push_back({in_data[i][WI-1], 2'(i), in_data[i][WD-1:0]});
    end
    if (rst && dv && dout_ready) begin
      out_q.push_back(dd);
      if (dd[WD-1:0] == 16'h1234) n1234 <= n1234 + 1;
    end
  end

  initial begin
    #400000;
    $display("FAIL timeout: simulation did not reach the summary");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [WO-1:0] ob(input logic e, input logic [1:0] c, input logic [15:0] d);
    return {e, c, d};
  endfunction

  logic [15:0] base [N];
  int          ord [N];
  int          rem [N];
  int          guard;
  int          nmin;

  initial begin
    base[0] = 16'hA000; base[1] = 16'hB001; base[2] = 16'hC002;
    ord[0] = 2; ord[1] = 0; ord[2] = 1;
    for (int i = 0; i < N; i++) begin
      in_data[i] = '0;
      rem[i] = 0;
    end
    rst = 1'b0;
    in_valid = '0;
    dout_ready = 1'b1;
    repeat (2) @(negedge clk);

    // Reset state, with inputs already requesting
    for (int i = 0; i < N; i++) in_data[i] = {1'b1, base[i]};
    in_valid = 3'b011;
    #1;
    chk("rst_valid", 32'(dv), 32'd0);
    chk("rst_data", 32'(dd), 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd0);

    // Two inputs with single-beat transactions alternate 0,1,0,1
    rst = 1'b1;
    #1;
    chk("A_ready0", 32'(in_ready), 32'b001);
    chk("A_novalid", 32'(dv), 32'd0);
    for (int k = 0; k < 4; k++) begin
      step();
      chk("A_valid", 32'(dv), 32'd1);
      chk("A_beat", 32'(dd), 32'(ob(1'b1, 2'(k % 2), base[k % 2])));
    end
    in_valid = '0;
    step();
    chk("A_idle", 32'(dv), 32'd0);

    // Pointer now at 2: all valid gives 2,0,1
    in_valid = 3'b111;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("D_wrap", 32'(dd), 32'(ob(1'b1, 2'(ord[k]), base[ord[k]])));
    end
    in_valid = '0;
    step();
    chk("D_idle", 32'(dv), 32'd0);

    // Three-beat transaction on input 1 holds off input 0
    in_data[1] = {1'b0, 16'h1110};
    in_valid = 3'b010;
    step();
    chk("B_beat0", 32'(dd), 32'(ob(1'b0, 2'd1, 16'h1110)));
    in_data[0] = {1'b1, base[0]};
    in_data[1] = {1'b0, 16'h1111};
    in_valid = 3'b011;
    #1;
    chk("B_lock_rdy1", 32'(in_ready), 32'b010);
    step();
    chk("B_beat1", 32'(dd), 32'(ob(1'b0, 2'd1, 16'h1111)));
    in_data[1] = {1'b1, 16'h1112};
    #1;
    chk("B_lock_rdy2", 32'(in_ready), 32'b010);
    step();
    chk("B_beat2", 32'(dd), 32'(ob(1'b1, 2'd1, 16'h1112)));
    in_valid = 3'b001;
    #1;
    chk("B_release_rdy", 32'(in_ready), 32'b001);
    step();
    chk("B_next", 32'(dd), 32'(ob(1'b1, 2'd0, base[0])));
    in_valid = '0;
    step();
    chk("B_idle", 32'(dv), 32'd0);

    // Backpressure: registered 0x1234 held for 4 cycles, then delivered once
    dout_ready = 1'b0;
    in_data[1] = {1'b1, 16'h1234};
    in_valid = 3'b010;
    step();
    in_data[0] = {1'b1, 16'h0C0C};
    in_valid = 3'b001;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("C_hold_valid", 32'(dv), 32'd1);
      chk("C_hold_data", 32'(dd), 32'(ob(1'b1, 2'd1, 16'h1234)));
      chk("C_hold_rdy", 32'(in_ready), 32'd0);
      step();
    end
    chk("C_hold_last", 32'(dd), 32'(ob(1'b1, 2'd1, 16'h1234)));
    dout_ready = 1'b1;
    #1;
    chk("C_release_rdy", 32'(in_ready), 32'b001);
    step();
    chk("C_next", 32'(dd), 32'(ob(1'b1, 2'd0, 16'h0C0C)));
    in_valid = '0;
    step();
    chk("C_idle", 32'(dv), 32'd0);
    chk("C_once", 32'(n1234), 32'd1);

    // Locked on input 0 while it stalls; input 1 must wait
    in_data[0] = {1'b0, 16'h0E00};
    in_valid = 3'b001;
    step();
    chk("E_beat0", 32'(dd), 32'(ob(1'b0, 2'd0, 16'h0E00)));
    in_data[1] = {1'b1, 16'h0E11};
    in_valid = 3'b010;
    #1;
    chk("E_stall_rdy", 32'(in_ready), 32'd0);
    for (int k = 0; k < 2; k++) begin
      step();
      chk("E_stall_valid", 32'(dv), 32'd0);
      chk("E_stall_rdy2", 32'(in_ready), 32'd0);
    end
    in_data[0] = {1'b1, 16'h0E01};
    in_valid = 3'b011;
    #1;
    chk("E_resume_rdy", 32'(in_ready), 32'b001);
    step();
    chk("E_beat1", 32'(dd), 32'(ob(1'b1, 2'd0, 16'h0E01)));
    in_valid = 3'b010;
    #1;
    chk("E_other_rdy", 32'(in_ready), 32'b010);
    step();
    chk("E_other", 32'(dd), 32'(ob(1'b1, 2'd1, 16'h0E11)));
    in_valid = '0;
    step();
    chk("E_idle", 32'(dv), 32'd0);

    // Randomized traffic: multi-beat transactions, idle gaps, random backpressure
    for (int c = 0; c < 300; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!in_valid[i] || acc_last[i]) begin
          if ($urandom_range(3) == 0) begin
            in_valid[i] = 1'b0;
          end else begin
            if (rem[i] == 0) rem[i] = $urandom_range(4, 1);
            rem[i] = rem[i] - 1;
            in_data[i] = {rem[i] == 0, 4'(i), 12'($urandom)};
            in_valid[i] = 1'b1;
          end
        end
      end
      dout_ready = ($urandom_range(3) != 0);
      #1;
      chk("R_onehot", 32'($onehot0(in_ready)), 32'd1);
      chk("R_rdy_valid", 32'(in_ready & ~in_valid), 32'd0);
      step();
    end

    // Finish every open transaction, then let the output slot drain
    dout_ready = 1'b1;
    guard = 0;
    while (guard < 100 && !(in_valid == '0 && rem[0] == 0 && rem[1] == 0 && rem[2] == 0)) begin
      for (int i = 0; i < N; i++) begin
        if (!in_valid[i] || acc_last[i]) begin
          if (rem[i] != 0) begin
            rem[i] = rem[i] - 1;
            in_data[i] = {rem[i] == 0, 4'(i), 12'($urandom)};
            in_valid[i] = 1'b1;
          end else begin
            in_valid[i] = 1'b0;
          end
        end
      end
      step();
      guard++;
    end
    chk("R_drain", 32'(guard < 100), 32'd1);
    in_valid = '0;
    repeat (3) step();

    // Delivered stream must equal the accepted stream, in order, with no interleaving
    chk("R_count", 32'(out_q.size()), 32'(acc_q.size()));
    nmin = (out_q.size() < acc_q.size()) ? out_q.size() : acc_q.size();
    for (int k = 0; k < nmin; k++) begin
      chk("R_beat", 32'(out_q[k]), 32'(acc_q[k]));
      if (k > 0 && !out_q[k-1][WO-1])
        chk("R_atomic", 32'(out_q[k][WO-2 -: 2]), 32'(out_q[k-1][WO-2 -: 2]));
    end

    // Reset during the second beat of a 3-beat transaction on input 2
    in_data[2] = {1'b0, 16'h0F20};
    in_valid = 3'b100;
    step();
    chk("F_beat0", 32'(dd), 32'(ob(1'b0, 2'd2, 16'h0F20)));
    in_data[2] = {1'b0, 16'h0F21};
    step();
    chk("F_beat1", 32'(dd), 32'(ob(1'b0, 2'd2, 16'h0F21)));
    rst = 1'b0;
    #1;
    chk("F_rst_valid", 32'(dv), 32'd0);
    chk("F_rst_data", 32'(dd), 32'd0);
    chk("F_rst_rdy", 32'(in_ready), 32'd0);
    in_data[0] = {1'b1, 16'h0F00};
    in_data[1] = {1'b1, 16'h0F10};
    in_data[2] = {1'b1, 16'h0F22};
    in_valid = 3'b111;
    step();
    chk("F_in_rst_valid", 32'(dv), 32'd0);
    rst = 1'b1;
    #1;
    chk("F_first_rdy", 32'(in_ready), 32'b001);
    step();
    chk("F_first_grant", 32'(dd), 32'(ob(1'b1, 2'd0, 16'h0F00)));
    in_valid = '0;
    step();
    step();
    chk("F_idle", 32'(dv), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/qrr_mux.md
QRR_MUX -- requirements
Module: qrr_mux

Interface
REQ-001 SHALL have parameter NUM_IN, default 2, giving the number of input queue streams (legal range 2..8).
REQ-002 SHALL have parameter W_DATA, default 16, giving the payload width per beat.
REQ-003 SHALL have parameter LVL, default 1, giving the queue eot width per beat.
REQ-004 SHALL derive localparam W_CTRL = max(1, clog2(NUM_IN)), giving the width of the output select tag.
REQ-005 SHALL have port clk, input, 1 bit: the single clock, rising edge active.
REQ-006 SHALL have port rst, input, 1 bit: asynchronous reset, active-low.
REQ-007 SHALL have port din, dti.consumer array [NUM_IN], data width LVL+W_DATA, laid out {eot[LVL-1:0], data[W_DATA-1:0]}: the requester queue streams.
REQ-008 SHALL have port dout, dti.producer, data width LVL+W_CTRL+W_DATA, laid out {eot, ctrl, data}: the merged stream in the union layout that the downstream filter consumes.

Function
REQ-009 SHALL merge the NUM_IN queue streams onto dout, switching between inputs only at transaction boundaries.
REQ-010 SHALL treat an accepted beat as the end of a transaction when its eot bits are all ones.
REQ-011 SHALL drive dout.ctrl with the index of the input that supplied the beat.
REQ-012 SHALL pass eot and data through unchanged.
REQ-013 SHALL use two states, UNLOCKED and LOCKED, holding a grant index g and a priority pointer p.
REQ-014 SHALL, in UNLOCKED, select as candidate the first valid input at or after p in order p, p+1, ... NUM_IN-1, 0, ... p-1.
REQ-015 SHALL, in UNLOCKED with no valid input, accept nothing and keep p unchanged.
REQ-016 SHALL, in LOCKED, consider only input g, regardless of the other inputs' valid signals.
REQ-017 SHALL define "can load" as: output register empty, or dout.valid && dout.ready in the same cycle.
REQ-018 SHALL assert din[i].ready only for the current candidate (UNLOCKED) or for g (LOCKED), and only when can load is true.
REQ-019 SHALL hold din[i].ready low for every other input.
REQ-020 SHALL register an accepted beat into a one-deep output register, giving exactly 1 cycle from din handshake to dout.valid.
REQ-021 SHALL not make dout.valid depend combinationally on any din signal.
REQ-022 SHALL sustain full throughput of 1 beat/cycle when dout.ready is held high.
REQ-023 SHALL hold dout.data stable while dout.valid is high and dout.ready is low.
REQ-024 SHALL clear the output register's valid on a dout handshake with no simultaneous load.
REQ-025 SHALL, on an accepted beat that is not end of transaction, enter or stay in LOCKED with g set to the source index.
REQ-026 SHALL, on an accepted end-of-transaction beat, go to UNLOCKED and set p = (source + 1) mod NUM_IN, wrapping NUM_IN-1 to 0.
REQ-027 SHALL, on an accepted single-beat transaction (first beat is also end of transaction) in UNLOCKED, stay UNLOCKED and update p per REQ-026.
REQ-028 SHALL, when input g drops valid in LOCKED, stall with no switch to another input and keep the lock.
REQ-029 SHALL make the dout handshake and the next load in the same cycle both take effect.

Reset
REQ-030 SHALL, while rst is low, asynchronously force dout.valid=0, dout.data=0, state=UNLOCKED, g=0, p=0, and all din[i].ready=0.
REQ-031 SHALL, on rst asserted mid-transaction, discard the partial transaction and the registered beat with no completion generated.
REQ-032 SHALL, after rst is released, start arbitration from input 0.

Verification
REQ-033 SHALL cover: after reset, din[0] and din[1] both valid with 1-beat transactions (eot=1), dout.ready=1 -> dout.ctrl sequence 0,1,0,1, one beat per cycle, first dout.valid 1 cycle after release.
REQ-034 SHALL cover: din[1] sends 3 beats (eot 0,0,1) while din[0] is valid throughout -> dout.ctrl=1,1,1 then 0, and din[0].ready stays 0 until din[1]'s eot beat is accepted.
REQ-035 SHALL cover: dout.ready held 0 for 4 cycles with beat data=0x1234 registered -> dout.data stays 0x1234, din ready all 0, beat delivered exactly once on release.
REQ-036 SHALL cover: NUM_IN=3, p=2, all valid -> grant order 2,0,1 (pointer wrap).
REQ-037 SHALL cover: LOCKED on input 0, din[0].valid low for 2 cycles while din[1] is valid -> no din[1] beat appears until din[0] completes its transaction.
REQ-038 SHALL cover: rst pulsed low during the second beat of a 3-beat transaction -> dout.valid=0 immediately, and after release the first grant goes to the lowest-index valid input.
